// File: rtl/comp_seq_ctrl.sv
// Row sequencer/collector behind the argmax comparator: walks the logit rows, pulses the
// comparator run per row, and collects the winning index/value into a flat result vector.
module comp_seq_ctrl #(
    parameter  int N_ROWS   = 10,
    parameter  int CHAR_LEN = 8,
    parameter  int N_LEN    = 16,
    parameter  int COMP_LAT = 8,
    parameter  int TMO      = 12,
    localparam int AW       = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int TW       = (TMO > 1) ? $clog2(TMO) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic [AW-1:0]              row_addr,
    output logic                       comp_run,
    input  logic                       comp_valid,
    input  logic [CHAR_LEN-1:0]        comp_num,
    input  logic [N_LEN-1:0]           comp_q,
    output logic                       valid,
    output logic                       err,
    output logic [N_ROWS*CHAR_LEN-1:0] chars,
    output logic [N_ROWS*N_LEN-1:0]    qs,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [AW-1:0]               r_row;
    logic [TW-1:0]               r_tmo;
    logic [N_ROWS*CHAR_LEN-1:0]  r_chars;
    logic [N_ROWS*N_LEN-1:0]     r_qs;
    logic                        w_capture;
    logic                        w_last_row;
    logic                        w_tmo_hit;

    assign w_last_row = (r_row == AW'(N_ROWS - 1));
    assign w_tmo_hit  = (r_tmo == TW'(TMO - 1));
    // Abort has priority over a same-cycle result, so capture requires run still high.
    assign w_capture  = (r_state == RUN) && run && comp_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (run) w_next = SETUP;
            SETUP: w_next = run ? RUN : IDLE;
            RUN: begin
                if (!run)
                    w_next = IDLE;
                else if (comp_valid)
                    w_next = w_last_row ? DONE : SETUP;
                else if (w_tmo_hit)
                    w_next = ERR;
            end
            DONE:  if (!run) w_next = IDLE;
            ERR:   if (!run) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_tmo   <= '0;
            r_chars <= '0;
            r_qs    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && run) begin
                r_row   <= '0;
                r_chars <= '0;
                r_qs    <= '0;
            end
            if (r_state == SETUP)
                r_tmo <= '0;
            else if (r_state == RUN)
                r_tmo <= r_tmo + 1'b1;
            if (w_capture) begin
                for (int r = 0; r < N_ROWS; r++) begin
                    if (r_row == AW'(r)) begin
                        r_chars[r*CHAR_LEN +: CHAR_LEN] <= comp_num;
                        r_qs[r*N_LEN +: N_LEN]          <= comp_q;
                    end
                end
                if (!w_last_row)
                    r_row <= r_row + 1'b1;
            end
        end
    end

    assign row_addr  = r_row;
    assign comp_run  = (r_state == RUN);
    assign valid     = (r_state == DONE);
    assign err       = (r_state == ERR);
    assign chars     = r_chars;
    assign qs        = r_qs;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed bench for comp_seq_ctrl with a small comparator model (valid on the 9th run cycle,
// num = 3*row+1, q = 100+row) and table-driven checks of the collected results.
module tb_comp_seq_ctrl;

    localparam int N_ROWS   = 10;
    localparam int CHAR_LEN = 8;
    localparam int N_LEN    = 16;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       run;
    logic [3:0]                 row_addr;
    logic                       comp_run;
    logic                       comp_valid;
    logic [CHAR_LEN-1:0]        comp_num;
    logic [N_LEN-1:0]           comp_q;
    logic                       valid;
    logic                       err;
    logic [N_ROWS*CHAR_LEN-1:0] chars;
    logic [N_ROWS*N_LEN-1:0]    qs;
    logic [2:0]                 dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    comp_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .row_addr   (row_addr),
        .comp_run   (comp_run),
        .comp_valid (comp_valid),
        .comp_num   (comp_num),
        .comp_q     (comp_q),
        .valid      (valid),
        .err        (err),
        .chars      (chars),
        .qs         (qs),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- comparator model ----------------
    logic [3:0] m_cnt = 4'd0;
    logic       m_force = 1'b0;
    logic       m_block = 1'b0;

    always @(posedge clk) begin
        if (!comp_run)
            m_cnt <= 4'd0;
        else if (m_cnt != 4'd15)
            m_cnt <= m_cnt + 4'd1;
    end

    assign comp_valid = m_force || (comp_run && m_cnt == 4'd8 && !(m_block && row_addr == 4'd2));
    assign comp_num   = 8'(3 * row_addr + 1);
    assign comp_q     = 16'(100 + row_addr);

    // ---------------- driver / checker tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] char_slot(input int r);
        return chars[r*CHAR_LEN +: CHAR_LEN];
    endfunction

    function automatic logic [15:0] q_slot(input int r);
        return qs[r*N_LEN +: N_LEN];
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int          row;
        logic [7:0]  exp_num;
        logic [15:0] exp_qv;
    } slot_vec_t;

    slot_vec_t   vecs[N_ROWS];
    logic [7:0]  exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edge_cnt;
        int valid_edge;
        int run_low_cnt;
        int n;
        logic [N_ROWS*CHAR_LEN-1:0] snap_chars;
        logic [N_ROWS*N_LEN-1:0]    snap_qs;

        vecs[0] = '{0,  8'd1, 16'd100};
        vecs[1] = '{1,  8'd4, 16'd101};
        vecs[2] = '{2,  8'd7, 16'd102};
        vecs[3] = '{3, 8'd10, 16'd103};
        vecs[4] = '{4, 8'd13, 16'd104};
        vecs[5] = '{5, 8'd16, 16'd105};
        vecs[6] = '{6, 8'd19, 16'd106};
        vecs[7] = '{7, 8'd22, 16'd107};
        vecs[8] = '{8, 8'd25, 16'd108};
        vecs[9] = '{9, 8'd28, 16'd109};

        // ---- reset ----
        rst = 1'b1;
        run = 1'b0;
        step(2);
        rst = 1'b0;
        chk("reset_state", 160'(dbg_state), 160'(S_IDLE));
        chk("reset_row", 160'(row_addr), 160'd0);
        chk("reset_comp_run", 160'(comp_run), 160'd0);
        chk("reset_valid", 160'(valid), 160'd0);
        chk("reset_err", 160'(err), 160'd0);
        chk("reset_chars", 160'(chars), 160'd0);
        chk("reset_qs", 160'(qs), 160'd0);

        // ---- nominal: edge 1 samples run=1, valid expected after edge 101 ----
        run = 1'b1;
        valid_edge  = 0;
        run_low_cnt = 0;
        for (int e = 1; e <= 150; e++) begin
            step(1);
            if (e <= 100 && !comp_run) run_low_cnt++;
            if (valid && valid_edge == 0) valid_edge = e;
            if (valid) break;
        end
        chk("nominal_valid_edge", 160'(valid_edge), 160'd101);
        chk("nominal_comp_run_gaps", 160'(run_low_cnt), 160'd10);
        chk("nominal_row_last", 160'(row_addr), 160'd9);
        chk("nominal_comp_run_done", 160'(comp_run), 160'd0);
        chk("nominal_err", 160'(err), 160'd0);
        for (int i = 0; i < N_ROWS; i++) exp_q.push_back(vecs[i].exp_num);
        for (int i = 0; i < N_ROWS; i++) begin
            chk($sformatf("char_slot%0d", vecs[i].row), 160'(char_slot(vecs[i].row)), 160'(exp_q.pop_front()));
            chk($sformatf("q_slot%0d", vecs[i].row), 160'(q_slot(vecs[i].row)), 160'(vecs[i].exp_qv));
        end

        // ---- hold in DONE for 20 cycles, spurious comp_valid in the middle ----
        snap_chars = chars;
        snap_qs    = qs;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            m_force = (c >= 5 && c < 10);
            step(1);
            if (valid && chars == snap_chars && qs == snap_qs && row_addr == 4'd9) n++;
        end
        m_force = 1'b0;
        chk("hold_stable_cycles", 160'(n), 160'd20);

        run = 1'b0;
        step(1);
        chk("drop_valid", 160'(valid), 160'd0);
        chk("drop_state", 160'(dbg_state), 160'(S_IDLE));
        chk("drop_chars_kept", 160'(chars), 160'(snap_chars));
        chk("drop_qs_kept", 160'(qs), 160'(snap_qs));

        // ---- restart with spurious comp_valid during SETUP ----
        run = 1'b1;
        m_force = 1'b1;
        step(1);
        chk("restart_state", 160'(dbg_state), 160'(S_SETUP));
        chk("restart_chars_clr", 160'(chars), 160'd0);
        chk("restart_qs_clr", 160'(qs), 160'd0);
        chk("restart_row", 160'(row_addr), 160'd0);
        step(1);
        m_force = 1'b0;
        chk("spurious_setup_state", 160'(dbg_state), 160'(S_RUN));
        chk("spurious_setup_row", 160'(row_addr), 160'd0);
        chk("spurious_setup_chars", 160'(chars), 160'd0);

        // ---- abort on row 5 with comp_valid in the same cycle ----
        n = 0;
        while (!(row_addr == 4'd5 && comp_valid && dbg_state == S_RUN) && n < 200) begin
            step(1);
            n++;
        end
        chk("abort_reached_row5", 160'(n < 200), 160'd1);
        run = 1'b0;
        step(1);
        chk("abort_state", 160'(dbg_state), 160'(S_IDLE));
        chk("abort_comp_run", 160'(comp_run), 160'd0);
        chk("abort_slot5_char", 160'(char_slot(5)), 160'd0);
        chk("abort_slot5_q", 160'(q_slot(5)), 160'd0);
        chk("abort_slot4_char", 160'(char_slot(4)), 160'd13);

        // ---- reset mid-RUN on row 4 with run held high ----
        run = 1'b1;
        n = 0;
        while (!(row_addr == 4'd4 && dbg_state == S_RUN) && n < 200) begin
            step(1);
            n++;
        end
        chk("rst_reached_row4", 160'(n < 200), 160'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_state", 160'(dbg_state), 160'(S_IDLE));
        chk("midrst_row", 160'(row_addr), 160'd0);
        chk("midrst_comp_run", 160'(comp_run), 160'd0);
        chk("midrst_chars", 160'(chars), 160'd0);
        chk("midrst_qs", 160'(qs), 160'd0);
        step(1);
        chk("midrst_restart_state", 160'(dbg_state), 160'(S_SETUP));
        chk("midrst_restart_row", 160'(row_addr), 160'd0);

        // ---- timeout on row 2 ----
        m_block = 1'b1;
        n = 0;
        while (!(row_addr == 4'd2 && comp_run) && n < 200) begin
            step(1);
            n++;
        end
        chk("tmo_reached_row2", 160'(n < 200), 160'd1);
        n = 0;
        while (!err && n < 30) begin
            step(1);
            n++;
        end
        chk("tmo_run_cycles", 160'(n), 160'd12);
        chk("tmo_state", 160'(dbg_state), 160'(S_ERR));
        chk("tmo_comp_run", 160'(comp_run), 160'd0);
        chk("tmo_valid", 160'(valid), 160'd0);
        chk("tmo_slot2_char", 160'(char_slot(2)), 160'd0);
        chk("tmo_slot1_char", 160'(char_slot(1)), 160'd4);
        step(5);
        chk("tmo_err_sticky", 160'(err), 160'd1);
        run = 1'b0;
        m_block = 1'b0;
        step(1);
        chk("tmo_err_clear", 160'(err), 160'd0);
        chk("tmo_idle", 160'(dbg_state), 160'(S_IDLE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
